// File: rtl/my_struct_package.sv
// Shared types for the L1-to-L2 responder path: MESI states, L2 message codes,
// responder FSM states, cache line layout and the address tag/index split.
package my_struct_package;

    localparam int PADDR_W  = 32;
    localparam int OFFSET_W = 6;   // 64-byte lines
    localparam int INDEX_W  = 14;
    localparam int TAG_W    = PADDR_W - INDEX_W - OFFSET_W;
    localparam int LRU_W    = 3;

    localparam logic [3:0] CMD_RD       = 4'd0;
    localparam logic [3:0] CMD_WR       = 4'd1;
    localparam logic [3:0] CMD_IFETCH   = 4'd2;
    localparam logic [3:0] CMD_L2_INV   = 4'd3;
    localparam logic [3:0] CMD_SNOOP_RD = 4'd4;
    localparam logic [3:0] CMD_CLEAR    = 4'd8;
    localparam logic [3:0] CMD_PRINT    = 4'd9;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_READ       = 3'd1,
        OP_WRITE      = 3'd2,
        OP_RFO        = 3'd3,
        OP_INVALIDATE = 3'd4,
        OP_RETURN     = 3'd5
    } l2_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_FILL = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } resp_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        mesi_t            mesi;
        logic [LRU_W-1:0] lru;
    } cache_line_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [PADDR_W-1:0] addr);
        addr_split_t s;
        s.tag   = addr[PADDR_W-1 -: TAG_W];
        s.index = addr[OFFSET_W +: INDEX_W];
        return s;
    endfunction

    function automatic logic [PADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                     input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_msg_port.sv
// L2 message port: holds l2_valid/l2_op/l2_addr stable until l2_ready.
// Optional trace logging and message counters under `L2_MSG_LOG_EN.
module l2_msg_port
    import my_struct_package::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  l2_op_t            issue_op,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              print,
    output logic              l2_valid,
    input  logic              l2_ready,
    output l2_op_t            l2_op,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              handshake
);

    assign handshake = l2_valid && l2_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            l2_valid <= 1'b0;
            l2_op    <= OP_NONE;
            l2_addr  <= '0;
        end else if (issue) begin
            l2_valid <= 1'b1;
            l2_op    <= issue_op;
            l2_addr  <= issue_addr;
        end else if (handshake) begin
            l2_valid <= 1'b0;
            l2_op    <= OP_NONE;
            l2_addr  <= '0;
        end
    end

`ifdef L2_MSG_LOG_EN
    logic [31:0] wr_cnt, rd_cnt, rfo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rfo_cnt <= '0;
        end else begin
            if (handshake) begin
                case (l2_op)
                    OP_READ: begin
                        rd_cnt <= rd_cnt + 32'd1;
                        $display("Read from L2 %h", l2_addr);
                    end
                    OP_WRITE: begin
                        wr_cnt <= wr_cnt + 32'd1;
                        $display("Write to L2 %h", l2_addr);
                    end
                    OP_RFO: begin
                        rfo_cnt <= rfo_cnt + 32'd1;
                        $display("Read for Ownership from L2 %h", l2_addr);
                    end
                    OP_INVALIDATE: $display("Invalidate %h", l2_addr);
                    OP_RETURN:     $display("Return data to L2 %h", l2_addr);
                    default: ;
                endcase
            end
            if (print)
                $display("L2 messages: reads %0d writes %0d rfo %0d", rd_cnt, wr_cnt, rfo_cnt);
        end
    end
`else
    logic unused_print;
    assign unused_print = print;
`endif

endmodule

// File: rtl/l2_responder.sv
// Next-level responder for resolved L1 lookups: sequences write-back/fill/
// invalidate/return messages to L2 and returns the updated line. Build option: L2_MSG_LOG_EN.
module l2_responder
    import my_struct_package::*;
#(
    parameter int ADDR_W     = 32,
    parameter int L2_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_hit,
    input  cache_line_t       victim_line,
    output logic              resp_valid,
    output cache_line_t       resp_line,
    output logic              l2_valid,
    input  logic              l2_ready,
    output l2_op_t            l2_op,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_shared
);

    resp_state_t       state, state_next;
    logic [CNT_W-1:0]  lat_cnt;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] line_addr_q;
    cache_line_t       line_q;
    l2_op_t            wb_op_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              need_fill_q;

    resp_state_t       plan_state;
    cache_line_t       plan_line;
    l2_op_t            plan_wb_op;
    logic [ADDR_W-1:0] plan_wb_addr;
    logic              plan_fill;
    logic              plan_print;

    addr_split_t       req_split;
    logic [ADDR_W-1:0] req_line_addr;
    logic              accept;
    logic              issue;
    l2_op_t            issue_op;
    logic [ADDR_W-1:0] issue_addr;
    logic              handshake;
    logic              unused_offset;

    assign req_split     = split_addr(PADDR_W'(req_addr));
    assign req_line_addr = ADDR_W'(line_addr(req_split.tag, req_split.index));
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_line  = line_q;
    assign accept     = req_valid && req_ready;

    // Decide the whole transaction at accept time; later states only replay it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        plan_state   = ST_RESP;
        plan_line    = victim_line;
        plan_wb_op   = OP_NONE;
        plan_wb_addr = ADDR_W'(line_addr(victim_line.tag, req_split.index));
        plan_fill    = 1'b0;
        plan_print   = 1'b0;
        case (req_n)
            CMD_RD, CMD_IFETCH, CMD_WR: begin
                // An invalid line cannot really hit, so it takes the miss path.
                if (!req_hit || victim_line.mesi == MESI_I) begin
                    plan_fill = 1'b1;
                    if (victim_line.mesi == MESI_M) begin
                        plan_state = ST_WB;
                        plan_wb_op = OP_WRITE;
                    end else begin
                        plan_state = ST_FILL;
                    end
                end else if (req_n == CMD_WR) begin
                    if (victim_line.mesi == MESI_E) begin
                        plan_line.mesi = MESI_M;
                    end else if (victim_line.mesi == MESI_S) begin
                        plan_state     = ST_WB;
                        plan_wb_op     = OP_INVALIDATE;
                        plan_wb_addr   = req_line_addr;
                        plan_line.mesi = MESI_M;
                    end
                end
            end
            CMD_L2_INV: begin
                if (req_hit) plan_line.mesi = MESI_I;
            end
            CMD_SNOOP_RD: begin
                if (req_hit && victim_line.mesi == MESI_M) begin
                    plan_state     = ST_WB;
                    plan_wb_op     = OP_RETURN;
                    plan_wb_addr   = req_line_addr;
                    plan_line.mesi = MESI_S;
                end else if (req_hit && victim_line.mesi == MESI_E) begin
                    plan_line.mesi = MESI_S;
                end
            end
            CMD_CLEAR: plan_line = '0;
            default:   plan_print = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_op   = OP_NONE;
        issue_addr = '0;
        case (state)
            ST_IDLE: if (req_valid) state_next = plan_state;
            ST_WB: begin
                issue      = !l2_valid;
                issue_op   = wb_op_q;
                issue_addr = wb_addr_q;
                if (handshake) state_next = need_fill_q ? ST_FILL : ST_RESP;
            end
            ST_FILL: begin
                issue      = !l2_valid;
                issue_op   = (cmd_q == CMD_WR) ? OP_RFO : OP_READ;
                issue_addr = line_addr_q;
                if (handshake) state_next = ST_WAIT;
            end
            ST_WAIT: if (lat_cnt <= CNT_W'(1)) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            cmd_q       <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            wb_op_q     <= OP_NONE;
            wb_addr_q   <= '0;
            need_fill_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd_q       <= req_n;
                line_addr_q <= req_line_addr;
                line_q      <= plan_line;
                wb_op_q     <= plan_wb_op;
                wb_addr_q   <= plan_wb_addr;
                need_fill_q <= plan_fill;
            end
            if (state == ST_FILL && handshake)
                lat_cnt <= CNT_W'(L2_LATENCY);
            else if (state == ST_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - CNT_W'(1);
            // Fill completes: install the requested tag, sharing decides S vs E.
            if (state == ST_WAIT && state_next == ST_RESP) begin
                line_q.tag  <= split_addr(PADDR_W'(line_addr_q)).tag;
                line_q.mesi <= (cmd_q == CMD_WR) ? MESI_M : (l2_shared ? MESI_S : MESI_E);
            end
        end
    end

    l2_msg_port #(.ADDR_W(ADDR_W)) u_msg_port (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .issue_op   (issue_op),
        .issue_addr (issue_addr),
        .print      (accept && plan_print),
        .l2_valid   (l2_valid),
        .l2_ready   (l2_ready),
        .l2_op      (l2_op),
        .l2_addr    (l2_addr),
        .handshake  (handshake)
    );

endmodule

// File: tb/tb_l2_responder.sv
// Self-checking bench for l2_responder: directed scenarios plus random
// transactions against a transaction-level reference model.
module tb_l2_responder;
    import my_struct_package::*;

    localparam int L2_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic [31:0] req_addr;
    logic        req_hit;
    cache_line_t victim_line;
    logic        resp_valid;
    cache_line_t resp_line;
    logic        l2_valid;
    logic        l2_ready;
    l2_op_t      l2_op;
    logic [31:0] l2_addr;
    logic        l2_shared;

    l2_responder #(.ADDR_W(32), .L2_LATENCY(L2_LATENCY), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_n       (req_n),
        .req_addr    (req_addr),
        .req_hit     (req_hit),
        .victim_line (victim_line),
        .resp_valid  (resp_valid),
        .resp_line   (resp_line),
        .l2_valid    (l2_valid),
        .l2_ready    (l2_ready),
        .l2_op       (l2_op),
        .l2_addr     (l2_addr),
        .l2_shared   (l2_shared)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        l2_op_t      op;
        logic [31:0] addr;
    } msg_t;

    msg_t        got_q[$];
    msg_t        exp_q[$];
    bit          exp_fill;
    cache_line_t exp_line;

    // L2 agent: stalls each message stall_cfg cycles, checks hold stability, logs handshakes.
    int     stall_cfg = 0;
    int     vcount = 0;
    l2_op_t held_op;
    logic [31:0] held_addr;

    always @(negedge clk) begin
        if (l2_valid) begin
            if (vcount > 0) begin
                check("l2_op_stable", l2_op, held_op);
                check("l2_addr_stable", l2_addr, held_addr);
            end
            held_op   = l2_op;
            held_addr = l2_addr;
            l2_ready  = (vcount >= stall_cfg);
            vcount++;
            if (l2_ready) begin
                got_q.push_back('{l2_op, l2_addr});
                vcount = 0;
            end
        end else begin
            vcount   = 0;
            l2_ready = 1'($urandom_range(0, 1));
        end
    end

    // Transaction-level reference: which messages, whether a fill happens, final line.
    task automatic model(input logic [3:0] cmd, input logic [31:0] addr, input logic hit,
                         input cache_line_t v, input logic shared);
        logic [31:0] laddr;
        laddr = addr & 32'hFFFF_FFC0;
        exp_q.delete();
        exp_fill = 0;
        exp_line = v;
        if (cmd <= 4'd2 && (!hit || v.mesi == MESI_I)) begin
            if (v.mesi == MESI_M)
                exp_q.push_back('{OP_WRITE, (32'(v.tag) << 20) | (addr & 32'h000F_FFC0)});
            exp_q.push_back('{(cmd == 4'd1) ? OP_RFO : OP_READ, laddr});
            exp_fill     = 1;
            exp_line.tag = 12'(addr >> 20);
            exp_line.mesi = (cmd == 4'd1) ? MESI_M : (shared ? MESI_S : MESI_E);
        end else if (cmd == 4'd1) begin
            if (v.mesi == MESI_S) exp_q.push_back('{OP_INVALIDATE, laddr});
            exp_line.mesi = MESI_M;
        end else if (cmd == 4'd3) begin
            if (hit) exp_line.mesi = MESI_I;
        end else if (cmd == 4'd4) begin
            if (hit && v.mesi == MESI_M) exp_q.push_back('{OP_RETURN, laddr});
            if (hit && (v.mesi == MESI_M || v.mesi == MESI_E)) exp_line.mesi = MESI_S;
        end else if (cmd == 4'd8) begin
            exp_line = '0;
        end
    endtask

    // Entered and left at a negedge.
    task automatic do_txn(input string name, input logic [3:0] cmd, input logic [31:0] addr,
                          input logic hit, input cache_line_t v, input logic shared, input int stall);
        int k;
        int exp_lat;
        model(cmd, addr, hit, v, shared);
        exp_lat = 1 + exp_q.size() * (2 + stall) + (exp_fill ? L2_LATENCY : 0);
        got_q.delete();
        stall_cfg   = stall;
        l2_shared   = shared;
        req_n       = cmd;
        req_addr    = addr;
        req_hit     = hit;
        victim_line = v;
        req_valid   = 1'b1;
        check({name, ":req_ready_idle"}, req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        if (!resp_valid) check({name, ":req_ready_busy"}, req_ready, 1'b0);
        while (!resp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, ":latency"}, k, exp_lat);
        check({name, ":resp_line"}, resp_line, exp_line);
        check({name, ":msg_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check({name, ":msg_op"}, got_q[i].op, exp_q[i].op);
                check({name, ":msg_addr"}, got_q[i].addr, exp_q[i].addr);
            end
        end
        @(negedge clk);
        check({name, ":resp_pulse"}, resp_valid, 1'b0);
        check({name, ":req_ready_back"}, req_ready, 1'b1);
    endtask

    function automatic cache_line_t mk_line(input logic [11:0] tag, input mesi_t m,
                                            input logic [2:0] lru);
        cache_line_t l;
        l.tag  = tag;
        l.mesi = m;
        l.lru  = lru;
        return l;
    endfunction

    initial begin
        int cmds[8];
        int resp_seen;
        cache_line_t v;
        logic [3:0] c;
        logic h;
        cmds = '{0, 1, 2, 3, 4, 8, 9, 6};

        rst = 1'b1;
        req_valid = 1'b0;
        req_n = '0;
        req_addr = '0;
        req_hit = 1'b0;
        victim_line = '0;
        l2_shared = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:req_ready", req_ready, 1'b1);
        check("rst:resp_valid", resp_valid, 1'b0);
        check("rst:resp_line", resp_line, 17'h0);
        check("rst:l2_valid", l2_valid, 1'b0);
        check("rst:l2_op", l2_op, OP_NONE);
        check("rst:l2_addr", l2_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_txn("rd_miss_I", 4'd0, 32'h0000_1040, 1'b0, mk_line(12'h000, MESI_I, 3'd5), 1'b0, 0);
        do_txn("wr_miss_M", 4'd1, 32'h4567_8A80, 1'b0, mk_line(12'h123, MESI_M, 3'd2), 1'b0, 0);
        do_txn("rd_stall5", 4'd0, 32'h0000_2080, 1'b0, mk_line(12'h3AA, MESI_S, 3'd1), 1'b0, 5);
        do_txn("wr_hit_S", 4'd1, 32'h00AB_CDC4, 1'b1, mk_line(12'h00A, MESI_S, 3'd0), 1'b0, 0);
        do_txn("wr_hit_E", 4'd1, 32'h00AB_CDC4, 1'b1, mk_line(12'h00A, MESI_E, 3'd7), 1'b0, 0);
        do_txn("snoop_M", 4'd4, 32'hFFF0_0FC8, 1'b1, mk_line(12'hFFF, MESI_M, 3'd3), 1'b0, 1);
        do_txn("inv_hit", 4'd3, 32'h1234_5678, 1'b1, mk_line(12'h123, MESI_E, 3'd4), 1'b0, 0);
        do_txn("rd_shared", 4'd0, 32'h0F0F_0F00, 1'b0, mk_line(12'h777, MESI_E, 3'd6), 1'b1, 0);
        do_txn("if_miss_M", 4'd2, 32'h8000_0040, 1'b0, mk_line(12'h800, MESI_M, 3'd1), 1'b0, 2);
        do_txn("clear", 4'd8, 32'h0000_0000, 1'b1, mk_line(12'h555, MESI_M, 3'd7), 1'b0, 0);
        do_txn("print", 4'd9, 32'h0000_0000, 1'b1, mk_line(12'h321, MESI_E, 3'd2), 1'b0, 0);
        do_txn("snoop_S", 4'd4, 32'h3210_0000, 1'b1, mk_line(12'h321, MESI_S, 3'd2), 1'b0, 0);

        // Reset while waiting on the fill latency.
        req_n = 4'd0;
        req_addr = 32'h0000_3000;
        req_hit = 1'b0;
        victim_line = mk_line(12'h000, MESI_I, 3'd0);
        stall_cfg = 0;
        l2_shared = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst:req_ready", req_ready, 1'b1);
        check("midrst:resp_valid", resp_valid, 1'b0);
        check("midrst:l2_valid", l2_valid, 1'b0);
        check("midrst:l2_op", l2_op, OP_NONE);
        rst = 1'b0;
        resp_seen = 0;
        repeat (L2_LATENCY + 4) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check("midrst:no_stale_resp", resp_seen, 0);
        do_txn("after_rst", 4'd0, 32'h0000_3040, 1'b0, mk_line(12'h000, MESI_I, 3'd3), 1'b1, 0);

        for (int n = 0; n < 60; n++) begin
            c = 4'(cmds[$urandom_range(0, 7)]);
            h = 1'($urandom_range(0, 1));
            v = mk_line(12'($urandom_range(0, 4095)), mesi_t'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)));
            if (c <= 4'd2 && h && v.mesi == MESI_I) v.mesi = MESI_S;
            do_txn("rand", c, $urandom, h, v, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
